regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb.sv | 138 +++++++++++++
 tb/tb_regfile_wr_arb.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arb
// Purpose  : Round-robin arbiter funnelling NREQ write requesters into a
//            single register-file write port, plus a pending-write
//            scoreboard (one bit per register).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   req_valid    [NREQ]            per-requester write request
//   req_num      [NREQ*ADDR_WIDTH] per-requester destination register
//   req_data     [NREQ*WIDTH]      per-requester write data
//   req_ready    [NREQ]            per-requester accept (combinational)
//   hold         blocks all accepts while high
//   issue_valid  mark issue_num as pending
//   issue_num    [ADDR_WIDTH]      register being marked pending
//   write        registered register-file write enable
//   writenum     [ADDR_WIDTH]      registered write address
//   data_in      [WIDTH]           registered write data
//   pending      [SIZE]            scoreboard, bit r = register r awaits write
// ============================================================================
module regfile_wr_arb #(
    parameter int WIDTH      = 16,
    parameter int SIZE       = 8,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int NREQ       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_num,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       hold,
    input  logic                       issue_valid,
    input  logic [ADDR_WIDTH-1:0]      issue_num,
    output logic                       write,
    output logic [ADDR_WIDTH-1:0]      writenum,
    output logic [WIDTH-1:0]           data_in,
    output logic [SIZE-1:0]            pending
);

    localparam int                c_PTR_W = $clog2(NREQ);
    localparam logic [c_PTR_W:0]  c_NREQ  = (c_PTR_W + 1)'(NREQ);

    logic [c_PTR_W-1:0]    r_ptr;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_writenum;
    logic [WIDTH-1:0]      r_data;
    logic [SIZE-1:0]       r_pending;

    logic                  w_accept;
    logic [c_PTR_W-1:0]    w_grant;
    logic [c_PTR_W:0]      w_cand;
    logic [c_PTR_W-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]       w_ready;
    logic [ADDR_WIDTH-1:0] w_num;
    logic [WIDTH-1:0]      w_data;
    logic [SIZE-1:0]       w_pending_nxt;

    // Search upward from the pointer, wrapping modulo NREQ. The candidate
    // carries one extra bit so ptr+k never overflows before the wrap.
    always_comb begin
        w_accept = 1'b0;
        w_grant  = '0;
        w_cand   = '0;
        if (!reset && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                w_cand = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
                if (w_cand >= c_NREQ) begin
                    w_cand = w_cand - c_NREQ;
                end
                if (!w_accept && req_valid[w_cand[c_PTR_W-1:0]]) begin
                    w_accept = 1'b1;
                    w_grant  = w_cand[c_PTR_W-1:0];
                end
            end
        end
    end

    // One-hot ready and the matching request fields.
    always_comb begin
        w_ready = '0;
        w_num   = '0;
        w_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_accept && (w_grant == c_PTR_W'(i))) begin
                w_ready[i] = 1'b1;
                w_num      = req_num[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_data     = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_grant == c_PTR_W'(NREQ - 1)) ? '0 : w_grant + 1'b1;

    // Clear for the write currently on the outputs, then set for a new
    // issue, so an issue to the same register wins.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int r = 0; r < SIZE; r++) begin
            if (r_write && (r_writenum == ADDR_WIDTH'(r))) begin
                w_pending_nxt[r] = 1'b0;
            end
            if (issue_valid && (issue_num == ADDR_WIDTH'(r))) begin
                w_pending_nxt[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_write    <= 1'b0;
            r_writenum <= '0;
            r_data     <= '0;
            r_pending  <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_write   <= w_accept;
            if (w_accept) begin
                r_ptr      <= w_ptr_nxt;
                r_writenum <= w_num;
                r_data     <= w_data;
            end
        end
    end

    assign req_ready = w_ready;
    assign write     = r_write;
    assign writenum  = r_writenum;
    assign data_in   = r_data;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arb
// Purpose  : Self-checking bench for regfile_wr_arb. Two instances (NREQ=2
//            and NREQ=4) run side by side against a cycle-level reference
//            model of the arbitration and scoreboard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arb;

    localparam int W  = 16;
    localparam int SZ = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    logic hold;
    logic issue_valid;
    logic [AW-1:0] issue_num;

    logic [1:0]      v2, rdy2;
    logic [2*AW-1:0] n2;
    logic [2*W-1:0]  dt2;
    logic            wr2;
    logic [AW-1:0]   wn2;
    logic [W-1:0]    di2;
    logic [SZ-1:0]   pd2;

    logic [3:0]      v4, rdy4;
    logic [4*AW-1:0] n4;
    logic [4*W-1:0]  dt4;
    logic            wr4;
    logic [AW-1:0]   wn4;
    logic [W-1:0]    di4;
    logic [SZ-1:0]   pd4;

    always #5 clk = ~clk;

    regfile_wr_arb #(.WIDTH(W), .SIZE(SZ), .ADDR_WIDTH(AW), .NREQ(2)) u_dut2 (
        .clk(clk), .reset(rst), .req_valid(v2), .req_num(n2), .req_data(dt2),
        .req_ready(rdy2), .hold(hold), .issue_valid(issue_valid),
        .issue_num(issue_num), .write(wr2), .writenum(wn2), .data_in(di2),
        .pending(pd2)
    );

    regfile_wr_arb #(.WIDTH(W), .SIZE(SZ), .ADDR_WIDTH(AW), .NREQ(4)) u_dut4 (
        .clk(clk), .reset(rst), .req_valid(v4), .req_num(n4), .req_data(dt4),
        .req_ready(rdy4), .hold(hold), .issue_valid(issue_valid),
        .issue_num(issue_num), .write(wr4), .writenum(wn4), .data_in(di4),
        .pending(pd4)
    );

    // Stimulus per DUT (index 0 = NREQ 2, index 1 = NREQ 4).
    logic          sv[2][4];
    logic [AW-1:0] sn[2][4];
    logic [W-1:0]  sd[2][4];

    // Reference model state.
    int            nreq[2] = '{2, 4};
    int            mptr[2];
    logic          mwr[2];
    logic [AW-1:0] mnum[2];
    logic [W-1:0]  mdat[2];
    logic [SZ-1:0] mpend[2];
    int            last_grant[2];

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First valid requester at or after the pointer, modulo NREQ; -1 if none.
    function automatic int exp_grant(input int d);
        if (rst || hold) return -1;
        for (int k = 0; k < nreq[d]; k++) begin
            int idx;
            idx = (mptr[d] + k) % nreq[d];
            if (sv[d][idx]) return idx;
        end
        return -1;
    endfunction

    task automatic apply();
        v2  = {sv[0][1], sv[0][0]};
        n2  = {sn[0][1], sn[0][0]};
        dt2 = {sd[0][1], sd[0][0]};
        for (int i = 0; i < 4; i++) begin
            v4[i]             = sv[1][i];
            n4[i*AW +: AW]    = sn[1][i];
            dt4[i*W +: W]     = sd[1][i];
        end
    endtask

    task automatic clear_stim();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                sv[d][i] = 1'b0;
                sn[d][i] = '0;
                sd[d][i] = '0;
            end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mptr[d]  = 0;
            mwr[d]   = 1'b0;
            mnum[d]  = '0;
            mdat[d]  = '0;
            mpend[d] = '0;
            last_grant[d] = -1;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [3:0] er;
            g  = exp_grant(d);
            er = (g < 0) ? 4'b0 : 4'(1 << g);
            check_eq($sformatf("ready%0d", d), (d == 0) ? {2'b00, rdy2} : rdy4, er);
            check_eq($sformatf("write%0d", d), (d == 0) ? wr2 : wr4, mwr[d]);
            check_eq($sformatf("writenum%0d", d), (d == 0) ? wn2 : wn4, mnum[d]);
            check_eq($sformatf("data_in%0d", d), (d == 0) ? di2 : di4, mdat[d]);
            check_eq($sformatf("pending%0d", d), (d == 0) ? pd2 : pd4, mpend[d]);
        end
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [SZ-1:0] np;
            g = exp_grant(d);
            last_grant[d] = g;
            if (rst) continue;
            np = mpend[d];
            if (mwr[d]) np[mnum[d]] = 1'b0;
            if (issue_valid) np[issue_num] = 1'b1;
            mpend[d] = np;
            if (g >= 0) begin
                mwr[d]  = 1'b1;
                mnum[d] = sn[d][g];
                mdat[d] = sd[d][g];
                mptr[d] = (g + 1) % nreq[d];
            end else begin
                mwr[d] = 1'b0;
            end
        end
    endtask

    // Accepted or idle requesters may take a fresh request; waiting ones stay put.
    task automatic refill();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < nreq[d]; i++)
                if (last_grant[d] == i || !sv[d][i]) begin
                    sv[d][i] = ($urandom_range(0, 99) < 60);
                    sn[d][i] = AW'($urandom);
                    sd[d][i] = W'($urandom);
                end
        hold        = ($urandom_range(0, 99) < 20);
        issue_valid = ($urandom_range(0, 99) < 30);
        issue_num   = AW'($urandom);
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
        if (rand_mode) refill();
        apply();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold = 1'b0;
        issue_valid = 1'b0;
        issue_num = '0;
        clear_stim();
        apply();
        model_reset();
        #1;
        check_eq("rst_write", wr2, 1'b0);
        check_eq("rst_pending", pd2, 8'h00);
        check_eq("rst_ready", rdy2, 2'b00);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        issue_valid = 1'b0;
        issue_num = '0;
        clear_stim();
        model_reset();
        apply();
        @(negedge clk);

        // Request presented during reset is neither accepted nor written later.
        sv[0][0] = 1'b1; sn[0][0] = 3'd6; sd[0][0] = 16'h1234;
        sv[1][2] = 1'b1; sn[1][2] = 3'd1; sd[1][2] = 16'h4321;
        apply();
        tick();
        tick();
        clear_stim();
        apply();
        rst = 1'b0;
        tick();
        check_eq("post_rst_write", wr2, 1'b0);

        // Single request.
        sv[0][0] = 1'b1; sn[0][0] = 3'd3; sd[0][0] = 16'h00A5;
        apply();
        #1;
        check_eq("single_ready", rdy2, 2'b01);
        tick();
        sv[0][0] = 1'b0;
        apply();
        check_eq("single_write", wr2, 1'b1);
        check_eq("single_num", wn2, 3'd3);
        check_eq("single_data", di2, 16'h00A5);
        tick();
        check_eq("single_idle", wr2, 1'b0);
        check_eq("single_keep", di2, 16'h00A5);

        // Contention after reset: 0,1,0,1 with no bubble.
        do_reset();
        sv[0][0] = 1'b1; sn[0][0] = 3'd1; sd[0][0] = 16'hAAAA;
        sv[0][1] = 1'b1; sn[0][1] = 3'd2; sd[0][1] = 16'hBBBB;
        apply();
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("cont_ready", rdy2, (c % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check_eq("cont_write", wr2, 1'b1);
        end

        // Hold with both valid, then release.
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("hold_ready", rdy2, 2'b00);
            tick();
            check_eq("hold_write", wr2, 1'b0);
        end
        hold = 1'b0;
        #1;
        check_eq("hold_release", rdy2, 2'b01);
        tick();
        clear_stim();
        apply();
        tick();

        // Scoreboard: issue r5, requester 1 writes r5.
        issue_valid = 1'b1; issue_num = 3'd5;
        tick();
        issue_valid = 1'b0;
        check_eq("sb_set", pd2[5], 1'b1);
        sv[0][1] = 1'b1; sn[0][1] = 3'd5; sd[0][1] = 16'h5555;
        apply();
        tick();
        sv[0][1] = 1'b0;
        apply();
        check_eq("sb_wr", wr2, 1'b1);
        check_eq("sb_still", pd2[5], 1'b1);
        tick();
        check_eq("sb_clear", pd2[5], 1'b0);
        // Issue r5 on the cycle write=1 for r5: set wins.
        sv[0][1] = 1'b1; sn[0][1] = 3'd5; sd[0][1] = 16'h6666;
        apply();
        tick();
        sv[0][1] = 1'b0;
        apply();
        issue_valid = 1'b1; issue_num = 3'd5;
        tick();
        issue_valid = 1'b0;
        check_eq("sb_setwins", pd2[5], 1'b1);
        tick();

        // Reset mid-operation with write=1 and pending=8'h24.
        do_reset();
        issue_valid = 1'b1; issue_num = 3'd2;
        tick();
        issue_num = 3'd5;
        sv[0][0] = 1'b1; sn[0][0] = 3'd3; sd[0][0] = 16'hC0DE;
        apply();
        tick();
        issue_valid = 1'b0;
        check_eq("mid_write", wr2, 1'b1);
        check_eq("mid_pend", pd2, 8'h24);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("mid_rst_write", wr2, 1'b0);
        check_eq("mid_rst_pend", pd2, 8'h00);
        check_eq("mid_rst_num", wn2, 3'd0);
        @(negedge clk);
        tick();
        clear_stim();
        apply();
        rst = 1'b0;
        tick();
        check_eq("mid_after", wr2, 1'b0);
        sv[0][0] = 1'b1; sv[0][1] = 1'b1;
        apply();
        #1;
        check_eq("mid_ptr0", rdy2, 2'b01);
        tick();
        clear_stim();
        apply();
        tick();

        // NREQ=4 rotation: pointer at 2, requesters 1 and 3 valid.
        do_reset();
        sv[1][1] = 1'b1; sn[1][1] = 3'd4; sd[1][1] = 16'h0101;
        apply();
        tick();
        sv[1][3] = 1'b1; sn[1][3] = 3'd7; sd[1][3] = 16'h0303;
        sd[1][1] = 16'h0111;
        apply();
        #1;
        check_eq("rot_first", rdy4, 4'b1000);
        tick();
        sv[1][3] = 1'b0;
        apply();
        check_eq("rot_data3", di4, 16'h0303);
        #1;
        check_eq("rot_second", rdy4, 4'b0010);
        tick();
        sv[1][1] = 1'b0;
        apply();
        check_eq("rot_data1", di4, 16'h0111);
        tick();

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
        end
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
